// File: rtl/audio_play_ctrl_if.sv
// Sample-source / DAC-driver bus of the playback sequencer.
// master = the sequencer, slave = sources, DAC driver and host.
interface audio_play_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
);
  logic              start;
  logic              stop;
  logic              src_sel;
  logic [ADDR_W-1:0] tbl_len;
  logic              req;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              fifo_empty;
  logic              fifo_rd;
  logic [DATA_W-1:0] fifo_q;
  logic [DATA_W-1:0] idata;
  logic              busy;
  logic [CNT_W-1:0]  underrun_cnt;

  modport master (
    input  start, stop, src_sel, tbl_len, req, rom_data, fifo_empty, fifo_q,
    output rom_addr, fifo_rd, idata, busy, underrun_cnt
  );
  modport slave (
    output start, stop, src_sel, tbl_len, req, rom_data, fifo_empty, fifo_q,
    input  rom_addr, fifo_rd, idata, busy, underrun_cnt
  );
endinterface

// File: rtl/audio_play_ctrl.sv
// Playback sequencer: services DAC sample requests from the tone ROM or stream FIFO.
// Optional AUDIO_HOLD_LAST_EN: a stream underrun holds the last sample instead of silence.
module audio_play_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  audio_play_ctrl_if.master  bus
);
  typedef enum logic [1:0] {IDLE, TONE, STREAM, STOPPING} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_r, addr_nx, len_r, len_nx;
  logic              src_r, src_nx;
  logic [DATA_W-1:0] idata_r, idata_nx;
  logic              rd_r, rd_nx, fwd_r;
  logic [CNT_W-1:0]  cnt_r, cnt_nx;
  logic              go;

  assign go = bus.start && !bus.stop;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:         if (go) state_nx = bus.src_sel ? STREAM : TONE;
      TONE, STREAM: if (bus.stop) state_nx = STOPPING;
      STOPPING:     if (bus.req) state_nx = IDLE;
      default:      state_nx = IDLE;
    endcase
  end

  always_comb begin
    addr_nx  = addr_r;
    len_nx   = len_r;
    src_nx   = src_r;
    idata_nx = idata_r;
    rd_nx    = 1'b0;
    cnt_nx   = cnt_r;
    bus.busy = (state != IDLE);
    // FIFO word arrives the cycle after the read strobe; commit what is forwarded.
    if (fwd_r) idata_nx = bus.fifo_q;
    case (state)
      IDLE: begin
        if (bus.req) idata_nx = '0;
        if (go) begin
          src_nx  = bus.src_sel;
          len_nx  = bus.tbl_len;
          addr_nx = '0;
        end
      end
      TONE, STREAM: begin
        if (bus.req) begin
          if (!src_r) begin
            idata_nx = bus.rom_data;
            addr_nx  = (addr_r == len_r) ? '0 : addr_r + 1'b1;
          end else if (!bus.fifo_empty) begin
            rd_nx = 1'b1;
          end else begin
`ifdef AUDIO_HOLD_LAST_EN
            idata_nx = idata_r;
`else
            idata_nx = '0;
`endif
            cnt_nx = (&cnt_r) ? cnt_r : cnt_r + 1'b1;
          end
        end
      end
      STOPPING: begin
        if (bus.req) begin
          idata_nx = '0;
          addr_nx  = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r  <= '0;
      len_r   <= '0;
      src_r   <= 1'b0;
      idata_r <= '0;
      rd_r    <= 1'b0;
      fwd_r   <= 1'b0;
      cnt_r   <= '0;
    end else begin
      addr_r  <= addr_nx;
      len_r   <= len_nx;
      src_r   <= src_nx;
      idata_r <= idata_nx;
      rd_r    <= rd_nx;
      fwd_r   <= rd_r;
      cnt_r   <= cnt_nx;
    end
  end

  // Forwarding fifo_q directly keeps the stream path at two cycles from req.
  assign bus.idata        = fwd_r ? bus.fifo_q : idata_r;
  assign bus.rom_addr     = addr_r;
  assign bus.fifo_rd      = rd_r;
  assign bus.underrun_cnt = cnt_r;
endmodule
